// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD read controller: FSM encoding, register-select
// constants, busy-flag bit position and default phase timing.
package lcd_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SETUP = 3'd1,
      ST_EHIGH = 3'd2,
      ST_HOLD  = 3'd3,
      ST_DONE  = 3'd4
   } lcd_state_e;

   localparam logic RS_INSTR = 1'b0;
   localparam logic RS_DATA  = 1'b1;
   localparam int   BF_BIT   = 7;

   localparam int DEF_SETUP_CYCLES  = 1;
   localparam int DEF_E_HIGH_CYCLES = 4;
   localparam int DEF_HOLD_CYCLES   = 1;
   localparam int DEF_TIMEOUT_POLLS = 255;

   localparam int TMR_W = 8;

   // Phase timer reload value: the timer sits in a phase for (load + 1) cycles.
   function automatic logic [TMR_W-1:0] phase_load(input int cycles, input int min_cycles);
      int n;
      n = (cycles < min_cycles) ? min_cycles : cycles;
      if (n > (1 << TMR_W)) n = (1 << TMR_W);
      return TMR_W'(n - 1);
   endfunction

endpackage

// File: rtl/lcd_phase_timer.sv
// Loadable down-counter with a zero flag; one instance times SETUP, EHIGH and HOLD.
module lcd_phase_timer
   import lcd_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [TMR_W-1:0] load_val,
   output logic             zero
);

   logic [TMR_W-1:0] cnt_q;
   logic [TMR_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(negedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero = (cnt_q == '0);

endmodule

// File: rtl/lcd_reader.sv
// HD44780-style LCD read controller (status or data read, optional busy polling).
// Optional poll timeout is enabled by defining LCD_READER_TIMEOUT_EN.
//
// state | meaning
// IDLE  | waiting for start; ready once settled
// SETUP | RS/RW driven, E low, address setup time
// EHIGH | E strobe high; bus captured on the final edge
// HOLD  | E low, RS/RW held; retries SETUP while polling a busy LCD
// DONE  | one-cycle valid pulse, then back to IDLE
module lcd_reader
   import lcd_pkg::*;
#(
   parameter int SETUP_CYCLES  = DEF_SETUP_CYCLES,
   parameter int E_HIGH_CYCLES = DEF_E_HIGH_CYCLES,
   parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
   parameter int TIMEOUT_POLLS = DEF_TIMEOUT_POLLS
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       regSel,
   input  logic       pollBusy,
   input  logic [7:0] lcdDataIn,
   output logic       enableOut,
   output logic       RS,
   output logic       RW,
   output logic       ready,
   output logic       valid,
   output logic [7:0] dataOut,
   output logic       busyFlag,
   output logic [6:0] addrOut,
   output logic       timeout
);

   localparam logic [TMR_W-1:0] SETUP_LOAD = phase_load(SETUP_CYCLES, 1);
   localparam logic [TMR_W-1:0] EHIGH_LOAD = phase_load(E_HIGH_CYCLES, 2);
   localparam logic [TMR_W-1:0] HOLD_LOAD  = phase_load(HOLD_CYCLES, 1);
   localparam logic [7:0]       TO_LIM     = (TIMEOUT_POLLS > 255) ? 8'd255 : 8'(TIMEOUT_POLLS);

`ifdef LCD_READER_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   lcd_state_e state_q, state_d;
   logic       rs_lat_q, rs_lat_d;
   logic       poll_en_q, poll_en_d;
   logic [7:0] poll_cnt_q, poll_cnt_d;
   logic [7:0] data_q, data_d;
   logic       busy_q, busy_d;
   logic [6:0] addr_q, addr_d;
   logic       timeout_q, timeout_d;
   logic       enable_q, enable_d;
   logic       rs_q, rs_d;
   logic       rw_q, rw_d;
   logic       ready_q, ready_d;
   logic       valid_q, valid_d;

   logic             tmr_load;
   logic [TMR_W-1:0] tmr_val;
   logic             tmr_zero;
   logic [7:0]       poll_inc;
   logic             poll_limit;

   lcd_phase_timer u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (tmr_load),
      .load_val (tmr_val),
      .zero     (tmr_zero)
   );

   assign poll_inc   = (poll_cnt_q == 8'hFF) ? 8'hFF : poll_cnt_q + 8'd1;
   assign poll_limit = TO_EN && (poll_inc >= TO_LIM);

   always_comb begin
      state_d    = state_q;
      rs_lat_d   = rs_lat_q;
      poll_en_d  = poll_en_q;
      poll_cnt_d = poll_cnt_q;
      data_d     = data_q;
      busy_d     = busy_q;
      addr_d     = addr_q;
      timeout_d  = timeout_q;
      tmr_load   = 1'b0;
      tmr_val    = '0;

      case (state_q)
         ST_IDLE: begin
            // ready_q gates acceptance so a start in the settling cycle is dropped
            if (start && ready_q) begin
               rs_lat_d   = regSel;
               poll_en_d  = pollBusy && (regSel == RS_INSTR);
               poll_cnt_d = 8'd0;
               timeout_d  = 1'b0;
               tmr_load   = 1'b1;
               tmr_val    = SETUP_LOAD;
               state_d    = ST_SETUP;
            end
         end
         ST_SETUP: begin
            if (tmr_zero) begin
               tmr_load = 1'b1;
               tmr_val  = EHIGH_LOAD;
               state_d  = ST_EHIGH;
            end
         end
         ST_EHIGH: begin
            if (tmr_zero) begin
               data_d = lcdDataIn;
               if (rs_lat_q == RS_INSTR) begin
                  busy_d = lcdDataIn[BF_BIT];
                  addr_d = lcdDataIn[6:0];
               end
               tmr_load = 1'b1;
               tmr_val  = HOLD_LOAD;
               state_d  = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (tmr_zero) begin
               if (poll_en_q && data_q[BF_BIT]) begin
                  poll_cnt_d = poll_inc;
                  if (poll_limit) begin
                     timeout_d = 1'b1;
                     state_d   = ST_DONE;
                  end else begin
                     tmr_load = 1'b1;
                     tmr_val  = SETUP_LOAD;
                     state_d  = ST_SETUP;
                  end
               end else begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Pin outputs follow the current state one edge later.
      ready_d  = (state_q == ST_IDLE) && (state_d == ST_IDLE);
      enable_d = (state_q == ST_EHIGH);
      rs_d     = (state_q != ST_IDLE) ? rs_lat_q : 1'b0;
      rw_d     = (state_q != ST_IDLE);
      valid_d  = (state_q == ST_DONE);
   end

   always_ff @(negedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         rs_lat_q   <= 1'b0;
         poll_en_q  <= 1'b0;
         poll_cnt_q <= 8'd0;
         data_q     <= 8'd0;
         busy_q     <= 1'b0;
         addr_q     <= 7'd0;
         timeout_q  <= 1'b0;
         enable_q   <= 1'b0;
         rs_q       <= 1'b0;
         rw_q       <= 1'b0;
         ready_q    <= 1'b0;
         valid_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         rs_lat_q   <= rs_lat_d;
         poll_en_q  <= poll_en_d;
         poll_cnt_q <= poll_cnt_d;
         data_q     <= data_d;
         busy_q     <= busy_d;
         addr_q     <= addr_d;
         timeout_q  <= timeout_d;
         enable_q   <= enable_d;
         rs_q       <= rs_d;
         rw_q       <= rw_d;
         ready_q    <= ready_d;
         valid_q    <= valid_d;
      end
   end

   assign enableOut = enable_q;
   assign RS        = rs_q;
   assign RW        = rw_q;
   assign ready     = ready_q;
   assign valid     = valid_q;
   assign dataOut   = data_q;
   assign busyFlag  = busy_q;
   assign addrOut   = addr_q;
   assign timeout   = timeout_q;

endmodule

// File: tb/tb_lcd_reader.sv
// Directed self-checking bench for lcd_reader; a second instance with
// TIMEOUT_POLLS=3 exercises the poll limit (behaviour depends on LCD_READER_TIMEOUT_EN).
module tb_lcd_reader;

   logic       clk = 1'b0;
   logic       rst, start, start_t, regSel, pollBusy;
   logic [7:0] lcd_static;
   bit         script_on;
   int         script_base;
   logic [7:0] lcd_bus;

   logic       enableOut, RS, RW, ready, valid, busyFlag, timeout;
   logic [7:0] dataOut;
   logic [6:0] addrOut;
   logic       enableOut_t, RS_t, RW_t, ready_t, valid_t, busyFlag_t, timeout_t;
   logic [7:0] dataOut_t;
   logic [6:0] addrOut_t;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   int e_pulses = 0, e_cycles = 0, v_count = 0, rw_bad = 0;
   int e_pulses_t = 0, v_count_t = 0;
   logic e_prev = 1'b0, e_prev_t = 1'b0, rs_at_e = 1'b0;

   always #5 clk = ~clk;

   // Busy for the first three strobes of a scripted poll, then clear with address 0x05.
   assign lcd_bus = script_on ? (((e_pulses - script_base) <= 3) ? 8'h80 : 8'h05) : lcd_static;

   lcd_reader dut (
      .clk(clk), .rst(rst), .start(start), .regSel(regSel), .pollBusy(pollBusy),
      .lcdDataIn(lcd_bus), .enableOut(enableOut), .RS(RS), .RW(RW), .ready(ready),
      .valid(valid), .dataOut(dataOut), .busyFlag(busyFlag), .addrOut(addrOut),
      .timeout(timeout)
   );

   lcd_reader #(.TIMEOUT_POLLS(3)) dut_t (
      .clk(clk), .rst(rst), .start(start_t), .regSel(regSel), .pollBusy(pollBusy),
      .lcdDataIn(lcd_bus), .enableOut(enableOut_t), .RS(RS_t), .RW(RW_t), .ready(ready_t),
      .valid(valid_t), .dataOut(dataOut_t), .busyFlag(busyFlag_t), .addrOut(addrOut_t),
      .timeout(timeout_t)
   );

   always @(negedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      e_prev   <= enableOut;
      e_prev_t <= enableOut_t;
      if (enableOut && !e_prev) e_pulses <= e_pulses + 1;
      if (enableOut) e_cycles <= e_cycles + 1;
      if (enableOut) rs_at_e <= RS;
      if (enableOut && RW !== 1'b1) rw_bad <= rw_bad + 1;
      if (valid) v_count <= v_count + 1;
      if (enableOut_t && !e_prev_t) e_pulses_t <= e_pulses_t + 1;
      if (valid_t) v_count_t <= v_count_t + 1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic start_txn(input bit alt, input logic rs, input logic pb, input bit hold,
                            output int t0);
      int n = 0;
      while (!(alt ? ready_t : ready) && n < 50) begin
         @(posedge clk);
         n++;
      end
      chk("ready_before_start", alt ? ready_t : ready, 1);
      regSel   = rs;
      pollBusy = pb;
      if (alt) start_t = 1'b1;
      else     start   = 1'b1;
      @(posedge clk);
      t0 = cyc;
      if (!hold) begin
         start   = 1'b0;
         start_t = 1'b0;
      end
   endtask

   task automatic wait_valid(input bit alt, input int t0, input int budget, output int lat);
      int n = 0;
      lat = -1;
      while (n < budget) begin
         @(posedge clk);
         n++;
         if (alt ? valid_t : valid) begin
            lat = cyc - t0;
            break;
         end
      end
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int t0, lat, ep0, ec0, v0, rb0, ept0, vt0;
      rst = 1'b0; start = 1'b0; start_t = 1'b0; regSel = 1'b0; pollBusy = 1'b0;
      lcd_static = 8'h00; script_on = 1'b0; script_base = 0;
      repeat (3) @(posedge clk);

      chk("rst_ready", ready, 0);
      chk("rst_enable", enableOut, 0);
      chk("rst_rs", RS, 0);
      chk("rst_rw", RW, 0);
      chk("rst_valid", valid, 0);
      chk("rst_data", dataOut, 0);
      chk("rst_busy", busyFlag, 0);
      chk("rst_addr", addrOut, 0);
      chk("rst_timeout", timeout, 0);
      rst = 1'b1;
      @(posedge clk);
      chk("ready_first_edge", ready, 1);

      // Data read of 0x41
      lcd_static = 8'h41;
      ep0 = e_pulses; ec0 = e_cycles; v0 = v_count; rb0 = rw_bad;
      start_txn(0, 1'b1, 1'b0, 0, t0);
      wait_valid(0, t0, 50, lat);
      chk("t1_latency", lat, 7);
      chk("t1_data", dataOut, 8'h41);
      chk("t1_ready_during_valid", ready, 0);
      chk("t1_e_cycles", e_cycles - ec0, 4);
      chk("t1_e_pulses", e_pulses - ep0, 1);
      chk("t1_rw_during_e", rw_bad - rb0, 0);
      chk("t1_rs_during_e", rs_at_e, 1);
      chk("t1_busy_untouched", busyFlag, 0);
      @(posedge clk);
      chk("t1_valid_width", valid, 0);
      chk("t1_ready_after", ready, 1);
      chk("t1_valid_count", v_count - v0, 1);

      // Status read without polling
      lcd_static = 8'h8A;
      start_txn(0, 1'b0, 1'b0, 0, t0);
      wait_valid(0, t0, 50, lat);
      chk("t2_latency", lat, 7);
      chk("t2_busy", busyFlag, 1);
      chk("t2_addr", addrOut, 7'h0A);
      chk("t2_data", dataOut, 8'h8A);
      chk("t2_timeout", timeout, 0);
      chk("t2_rs_during_e", rs_at_e, 0);

      // Busy poll: three busy reads then clear
      @(posedge clk);
      ep0 = e_pulses; v0 = v_count;
      script_base = e_pulses;
      script_on = 1'b1;
      start_txn(0, 1'b0, 1'b1, 0, t0);
      wait_valid(0, t0, 200, lat);
      chk("t3_latency", lat, 25);
      chk("t3_busy", busyFlag, 0);
      chk("t3_addr", addrOut, 7'h05);
      chk("t3_data", dataOut, 8'h05);
      repeat (10) @(posedge clk);
      chk("t3_e_pulses", e_pulses - ep0, 4);
      chk("t3_valid_count", v_count - v0, 1);
      script_on = 1'b0;

      // Poll limit on the TIMEOUT_POLLS=3 instance with a permanently busy LCD
      lcd_static = 8'hFF;
      ept0 = e_pulses_t; vt0 = v_count_t;
      start_txn(1, 1'b0, 1'b1, 0, t0);
`ifdef LCD_READER_TIMEOUT_EN
      wait_valid(1, t0, 200, lat);
      chk("t4_latency", lat, 19);
      chk("t4_timeout", timeout_t, 1);
      chk("t4_busy", busyFlag_t, 1);
      chk("t4_addr", addrOut_t, 7'h7F);
      chk("t4_e_pulses", e_pulses_t - ept0, 3);
      @(posedge clk);
      chk("t4_valid_count", v_count_t - vt0, 1);
`else
      wait_valid(1, t0, 1000, lat);
      chk("t4_no_valid", lat, 32'hFFFF_FFFF);
      chk("t4_timeout_zero", timeout_t, 0);
      chk("t4_busy_polling", busyFlag_t, 1);
      rst = 1'b0;
      repeat (2) @(posedge clk);
      rst = 1'b1;
      @(posedge clk);
      chk("t4_ready_after_abort", ready_t, 1);
`endif
      @(posedge clk);

      // start held high across a whole transaction
      lcd_static = 8'h3C;
      ep0 = e_pulses; v0 = v_count;
      start_txn(0, 1'b1, 1'b0, 1, t0);
      wait_valid(0, t0, 50, lat);
      start = 1'b0;
      chk("t5_latency", lat, 7);
      chk("t5_data", dataOut, 8'h3C);
      @(posedge clk);
      chk("t5_ready_after", ready, 1);
      repeat (3) @(posedge clk);
      chk("t5_e_pulses", e_pulses - ep0, 1);
      chk("t5_valid_count", v_count - v0, 1);

      // Async reset during EHIGH with start still held
      lcd_static = 8'h77;
      v0 = v_count;
      start_txn(0, 1'b1, 1'b0, 1, t0);
      repeat (2) @(posedge clk);
      chk("t6_e_high", enableOut, 1);
      #1 rst = 1'b0;
      #1;
      chk("t6_e_async_drop", enableOut, 0);
      chk("t6_ready", ready, 0);
      chk("t6_rs", RS, 0);
      chk("t6_rw", RW, 0);
      chk("t6_valid", valid, 0);
      chk("t6_data", dataOut, 0);
      chk("t6_addr", addrOut, 0);
      chk("t6_busy", busyFlag, 0);
      repeat (5) @(posedge clk);
      start = 1'b0;
      rst = 1'b1;
      repeat (10) @(posedge clk);
      chk("t6_no_valid", v_count - v0, 0);
      chk("t6_ready_after", ready, 1);

      // Clean transaction after the abort
      lcd_static = 8'h5A;
      start_txn(0, 1'b1, 1'b0, 0, t0);
      wait_valid(0, t0, 50, lat);
      chk("t7_latency", lat, 7);
      chk("t7_data", dataOut, 8'h5A);
      chk("t7_rs_during_e", rs_at_e, 1);

      repeat (2) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
